cla_addsub_pipe: RTL and testbench

//  Parametrised, pipelined carry-lookahead add/subtract unit for the ALU AddSubUnit.

---
 rtl/cla_addsub_pipe.sv | 166 ++++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead add/subtract: one BLK_W-bit lookahead block resolved per stage,
// inter-block carry registered, valid/ready on both sides, sum plus c_out/ovf/zero/neg flags.
module cla_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int BLK_W = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NUM_BLK = WIDTH / BLK_W;
  localparam int LAST    = NUM_BLK - 1;

  typedef struct packed {
    logic [BLK_W-1:0] s;
    logic             co;
    logic             cm;
  } cla_t;

  // Each carry is the flattened lookahead sum of generate terms and the block carry-in.
  function automatic cla_t cla_blk(input logic [BLK_W-1:0] x, input logic [BLK_W-1:0] y,
                                   input logic ci);
    logic [BLK_W-1:0] g;
    logic [BLK_W-1:0] p;
    logic [BLK_W:0]   c;
    logic             acc;
    logic             pp;
    cla_t             res;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLK_W; i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (g[j] & pp);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (ci & pp);
    end
    res.s  = p ^ c[BLK_W-1:0];
    res.co = c[BLK_W];
    res.cm = c[BLK_W-1];
    return res;
  endfunction

  logic [NUM_BLK-1:0] r_vld;
  logic [WIDTH-1:0]   r_a   [NUM_BLK];
  logic [WIDTH-1:0]   r_b   [NUM_BLK];
  logic [WIDTH-1:0]   r_s   [NUM_BLK];
  logic               r_c   [NUM_BLK];
  logic [TAG_W-1:0]   r_tag [NUM_BLK];
  logic               r_ovf;
  logic               r_zero;
  logic               r_neg;

  logic [NUM_BLK-1:0] w_iv;
  logic [WIDTH-1:0]   w_ia   [NUM_BLK];
  logic [WIDTH-1:0]   w_ib   [NUM_BLK];
  logic [WIDTH-1:0]   w_is   [NUM_BLK];
  logic [WIDTH-1:0]   w_ns   [NUM_BLK];
  logic               w_ic   [NUM_BLK];
  logic [TAG_W-1:0]   w_itag [NUM_BLK];
  cla_t               w_res  [NUM_BLK];
  logic [NUM_BLK-1:0] w_ld;
  logic [NUM_BLK-1:0] w_mv;

  // Stage 0 takes the ports directly (B pre-inverted for subtract); later stages take
  // the previous slot's operands, partial sum and registered carry.
  always_comb begin
    for (int k = 0; k < NUM_BLK; k++) begin
      if (k == 0) begin
        w_iv[k]   = in_valid;
        w_ia[k]   = a;
        w_ib[k]   = sub ? ~b : b;
        w_ic[k]   = sub | c_in;
        w_is[k]   = '0;
        w_itag[k] = in_tag;
      end else begin
        w_iv[k]   = r_vld[k-1];
        w_ia[k]   = r_a[k-1];
        w_ib[k]   = r_b[k-1];
        w_ic[k]   = r_c[k-1];
        w_is[k]   = r_s[k-1];
        w_itag[k] = r_tag[k-1];
      end
      w_res[k] = cla_blk(w_ia[k][k*BLK_W +: BLK_W], w_ib[k][k*BLK_W +: BLK_W], w_ic[k]);
      w_ns[k]  = w_is[k];
      w_ns[k][k*BLK_W +: BLK_W] = w_res[k].s;
    end
  end

  // A slot loads when empty or when its occupant moves on; ready ripples back from out_ready.
  always_comb begin
    w_mv       = '0;
    w_ld       = '0;
    w_mv[LAST] = r_vld[LAST] & out_ready;
    for (int k = LAST; k >= 0; k--) begin
      w_ld[k] = ~r_vld[k] | w_mv[k];
      if (k > 0) begin
        w_mv[k-1] = r_vld[k-1] & w_ld[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      for (int k = 0; k < NUM_BLK; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
        r_c[k]   <= 1'b0;
        r_tag[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_BLK; k++) begin
        if (w_ld[k]) begin
          r_vld[k] <= w_iv[k];
          if (w_iv[k]) begin
            r_a[k]   <= w_ia[k];
            r_b[k]   <= w_ib[k];
            r_s[k]   <= w_ns[k];
            r_c[k]   <= w_res[k].co;
            r_tag[k] <= w_itag[k];
          end
        end
      end
      if (w_ld[LAST] && w_iv[LAST]) begin
        r_ovf  <= w_res[LAST].co ^ w_res[LAST].cm;
        r_zero <= ~|w_ns[LAST];
        r_neg  <= w_ns[LAST][WIDTH-1];
      end
    end
  end

  assign in_ready  = w_ld[0];
  assign out_valid = r_vld[LAST];
  assign sum       = r_s[LAST];
  assign c_out     = r_c[LAST];
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign out_tag   = r_tag[LAST];

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: hand-computed vector table, streaming, back-pressure,
// mid-stream reset and randomized traffic at 32/8 and 64/16 against a behavioural model.
module tb_cla_addsub_pipe;
  localparam int NB = 4;

  typedef struct packed {
    logic [63:0] sum;
    logic        co;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  typedef struct {
    res_t       r;
    logic [3:0] tag;
    int         acc;
    bit         lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    res_t        r;
  } vec_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf, zero, neg;
  logic [31:0] a, b, sum;
  logic [3:0]  in_tag, out_tag;

  logic        d_in_valid, d_in_ready, d_c_in, d_sub, d_out_valid, d_out_ready;
  logic        d_c_out, d_ovf, d_zero, d_neg;
  logic [63:0] d_a, d_b, d_sum;
  logic [3:0]  d_in_tag, d_out_tag;

  int   n_chk, n_err, cyc;
  exp_t q[$];
  exp_t q64[$];
  exp_t drv_exp;
  vec_t tbl[12];

  cla_addsub_pipe #(.WIDTH(32), .BLK_W(8), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero), .neg(neg), .out_tag(out_tag));

  cla_addsub_pipe #(.WIDTH(64), .BLK_W(16), .TAG_W(4)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready), .a(d_a),
    .b(d_b), .c_in(d_c_in), .sub(d_sub), .in_tag(d_in_tag), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .sum(d_sum), .c_out(d_c_out), .ovf(d_ovf), .zero(d_zero),
    .neg(d_neg), .out_tag(d_out_tag));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Two's-complement reference built from plain wide addition, not from lookahead terms.
  function automatic res_t ref_op(input int w, input logic [63:0] x, input logic [63:0] y,
                                  input logic ci, input logic s);
    logic [63:0] mask, xx, yy;
    logic [64:0] full;
    res_t        r;
    mask   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    xx     = x & mask;
    yy     = (s ? ~y : y) & mask;
    full   = {1'b0, xx} + {1'b0, yy} + {64'd0, (s ? 1'b1 : ci)};
    r.sum  = full[63:0] & mask;
    r.co   = (w == 64) ? full[64] : full[32];
    r.neg  = r.sum[w-1];
    r.zero = (r.sum == 64'd0);
    r.ovf  = (xx[w-1] == yy[w-1]) && (r.sum[w-1] != xx[w-1]);
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] x, input logic [31:0] y, input logic ci,
                              input logic s, input logic [31:0] es, input logic eco,
                              input logic eovf, input logic ez, input logic en);
    vec_t v;
    v.a = x; v.b = y; v.cin = ci; v.sub = s;
    v.r = '{sum: {32'd0, es}, co: eco, ovf: eovf, zero: ez, neg: en};
    return v;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Settle, score any transfer happening at the coming edge, then advance one cycle.
  task automatic tick();
    exp_t e;
    #1;
    if (in_valid && in_ready) begin
      e     = drv_exp;
      e.tag = in_tag;
      e.acc = cyc;
      q.push_back(e);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = q.pop_front();
        check("result", {32'd0, sum, c_out, ovf, zero, neg, out_tag},
              {e.r.sum, e.r.co, e.r.ovf, e.r.zero, e.r.neg, e.tag});
        if (e.lat) check("latency", cyc - e.acc, NB);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_rand(input logic [3:0] t, input bit lat);
    a = rand_op(); b = rand_op(); c_in = 1'($urandom); sub = 1'($urandom);
    in_tag = t; in_valid = 1'b1;
    drv_exp.r   = ref_op(32, {32'd0, a}, {32'd0, b}, c_in, sub);
    drv_exp.lat = lat;
  endtask

  task automatic drain(input int budget);
    int n;
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while (q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [31:0] hold_sum;
    logic [3:0]  hold_tag;
    int          n_acc, n;
    exp_t        e;

    tbl[0]  = mk(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0, 1, 0);
    tbl[1]  = mk(32'h8000_0000, 32'h0000_0001, 1, 1, 32'h7FFF_FFFF, 1, 1, 0, 0);
    tbl[2]  = mk(32'h7FFF_FFFF, 32'h0000_0000, 1, 0, 32'h8000_0000, 0, 1, 0, 1);
    tbl[3]  = mk(32'h0000_0005, 32'h0000_0007, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 1);
    tbl[4]  = mk(32'h1234_5678, 32'h0000_00FF, 0, 0, 32'h1234_5777, 0, 0, 0, 0);
    tbl[5]  = mk(32'h00FF_00FF, 32'h0001_0001, 1, 0, 32'h0100_0101, 0, 0, 0, 0);
    tbl[6]  = mk(32'h0000_0000, 32'h0000_0000, 0, 1, 32'h0000_0000, 1, 0, 1, 0);
    tbl[7]  = mk(32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0000_0000, 1, 1, 1, 0);
    tbl[8]  = mk(32'hA5A5_A5A5, 32'h5A5A_5A5A, 0, 1, 32'h4B4B_4B4B, 1, 1, 0, 0);
    tbl[9]  = mk(32'hFFFF_FF00, 32'h0000_0100, 0, 0, 32'h0000_0000, 1, 0, 1, 0);
    tbl[10] = mk(32'h00FF_FFFF, 32'h0000_0001, 0, 0, 32'h0100_0000, 0, 0, 0, 0);
    tbl[11] = mk(32'h0000_0000, 32'h0000_0001, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 1);

    n_chk = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0;
    sub = 1'b0; in_tag = '0; drv_exp = '{r: '0, tag: '0, acc: 0, lat: 1'b0};
    d_in_valid = 1'b0; d_out_ready = 1'b1; d_a = '0; d_b = '0; d_c_in = 1'b0;
    d_sub = 1'b0; d_in_tag = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_outputs", {sum, c_out, ovf, zero, neg, out_tag}, 0);
    check("rst_out_valid64", d_out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: one op at a time, hand-computed results and exact latency.
    for (int i = 0; i < 12; i++) begin
      a = tbl[i].a; b = tbl[i].b; c_in = tbl[i].cin; sub = tbl[i].sub;
      in_tag = 4'(i); in_valid = 1'b1;
      drv_exp.r = tbl[i].r; drv_exp.lat = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (q.size() > 0 && n < 10) begin
        tick();
        n++;
      end
      check("table_done", q.size(), 0);
    end

    // Streaming: 16 back-to-back ops, one result per cycle after the fill latency.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_rand(4'(i), 1'b1);
      tick();
    end
    drain(12);

    // Back-pressure: only NB ops fit, outputs frozen while stalled.
    out_ready = 1'b0; n_acc = 0;
    hold_sum = '0; hold_tag = '0;
    for (int i = 0; i < 10; i++) begin
      drive_rand(4'(i), 1'b0);
      #1;
      if (in_ready) n_acc++;
      tick();
      if (i == 4) begin
        hold_sum = sum;
        hold_tag = out_tag;
      end
      if (i > 4) check("stall_stable", {sum, out_tag}, {hold_sum, hold_tag});
    end
    check("stall_accepts", n_acc, NB);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);

    // Full pipe: pop and accept in the same cycle, then the pipe is still full.
    drive_rand(4'hA, 1'b0);
    out_ready = 1'b1;
    #1;
    check("full_pop_accept", {in_ready, out_valid}, 2'b11);
    tick();
    out_ready = 1'b0;
    drive_rand(4'hB, 1'b0);
    #1;
    check("still_full", {in_ready, out_valid}, 2'b01);
    drain(12);

    // Reset with three ops in flight, oldest at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand(4'(i + 5), 1'b0);
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check("inflight_visible", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_outputs", {sum, out_tag, in_ready}, {32'd0, 4'd0, 1'b1});
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) n++;
      tick();
    end
    check("no_stale", n, 0);

    // Random traffic with random stalls on both sides.
    for (int i = 0; i < 150; i++) begin
      drive_rand(4'($urandom), 1'b0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain(20);

    // Random traffic on the 64-bit / 16-bit-block instance.
    for (int i = 0; i < 160; i++) begin
      if (i < 140) begin
        d_a = {$urandom, $urandom}; d_b = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) d_b = ~d_a;
        d_c_in = 1'($urandom); d_sub = 1'($urandom); d_in_tag = 4'($urandom);
        d_in_valid  = ($urandom_range(0, 9) < 7);
        d_out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        d_in_valid = 1'b0; d_out_ready = 1'b1;
      end
      #1;
      if (d_in_valid && d_in_ready) begin
        e.r = ref_op(64, d_a, d_b, d_c_in, d_sub);
        e.tag = d_in_tag; e.acc = cyc; e.lat = 1'b0;
        q64.push_back(e);
      end
      if (d_out_valid && d_out_ready) begin
        if (q64.size() == 0) begin
          check("unexpected_out64", 1, 0);
        end else begin
          e = q64.pop_front();
          check("result64", {d_sum, d_c_out, d_ovf, d_zero, d_neg, d_out_tag},
                {e.r.sum, e.r.co, e.r.ovf, e.r.zero, e.r.neg, e.tag});
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_empty64", q64.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
